// File: rtl/sigrun_xarb_pkg.sv
// Shared constants and types for the sigrun xbus arbiter.
package sigrun_xarb_pkg;

  localparam logic [31:0] XARB_TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int unsigned XARB_MAX_MASTERS  = 8;
  localparam int unsigned XARB_MID_W        = $clog2(XARB_MAX_MASTERS);

  typedef logic [XARB_MID_W-1:0] xarb_mid_t;

endpackage

// File: rtl/sigrun_xarb_fifo.sv
// Synchronous FIFO holding master ids of outstanding reads; push and pop may coincide.
module sigrun_xarb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sigrun_xbus_arbiter.sv
// Round-robin arbiter sharing one split-response slave among NUM_MASTERS requesters.
// Optional read timeout enabled by defining SIGRUN_XARB_TIMEOUT_EN.
module sigrun_xbus_arbiter
  import sigrun_xarb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned RESP_FIFO_DEPTH = 4,
  parameter int unsigned RESP_TIMEOUT    = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*32-1:0] m_addr_bi,
  input  logic [NUM_MASTERS*4-1:0]  m_be_bi,
  input  logic [NUM_MASTERS*32-1:0] m_wdata_bi,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_resp_o,
  output logic [NUM_MASTERS*32-1:0] m_rdata_bo,
  output logic                      s_req_o,
  output logic                      s_we_o,
  output logic [31:0]               s_addr_bo,
  output logic [3:0]                s_be_bo,
  output logic [31:0]               s_wdata_bo,
  input  logic                      s_ack_i,
  input  logic                      s_resp_i,
  input  logic [31:0]               s_rdata_bi,
  output logic                      busy_o
);

  logic [XARB_MAX_MASTERS-1:0] req_ext, we_ext;
  xarb_mid_t rr_ptr_q, rr_ptr_d, gnt_idx, fifo_head;
  logic      gnt_valid, gnt_we, hs, push, fifo_full, fifo_empty;
  logic      resp_fire, stray, err_q;
  logic [31:0] resp_data;

  assign req_ext = XARB_MAX_MASTERS'(m_req_i);
  assign we_ext  = XARB_MAX_MASTERS'(m_we_i);

  always_comb begin : p_grant
    int unsigned cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!gnt_valid && req_ext[xarb_mid_t'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = xarb_mid_t'(cand);
      end
    end
  end

  // Full is sampled before any same-cycle pop, so a full FIFO always stalls reads.
  assign gnt_we   = we_ext[gnt_idx];
  assign s_req_o  = gnt_valid && (gnt_we || !fifo_full);
  assign hs       = s_req_o && s_ack_i;
  assign push     = hs && !gnt_we;
  assign busy_o   = !fifo_empty;
  assign rr_ptr_d = (gnt_idx == xarb_mid_t'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef SIGRUN_XARB_TIMEOUT_EN
  localparam int unsigned ToW   = $clog2(RESP_TIMEOUT) + 1;
  localparam int unsigned DropW = $clog2(RESP_FIFO_DEPTH) + 2;

  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
  logic             swallow, real_resp, to_fire;

  // Responses owed to already-timed-out reads are absorbed before reaching the FIFO.
  assign swallow   = s_resp_i && (drop_cnt_q != '0);
  assign real_resp = s_resp_i && !swallow && !fifo_empty;
  assign to_fire   = !fifo_empty && !real_resp && (to_cnt_q == ToW'(RESP_TIMEOUT - 1));
  assign resp_fire = real_resp || to_fire;
  assign resp_data = to_fire ? XARB_TIMEOUT_DATA : s_rdata_bi;
  assign stray     = s_resp_i && !swallow && fifo_empty;

  always_comb begin
    to_cnt_d   = to_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (resp_fire || (push && fifo_empty)) begin
      to_cnt_d = '0;
    end else if (!fifo_empty) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (to_fire && !swallow) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (swallow && !to_fire) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`else
  assign resp_fire = s_resp_i && !fifo_empty;
  assign resp_data = s_rdata_bi;
  assign stray     = s_resp_i && fifo_empty;
`endif

  always_comb begin
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    m_ack_o    = '0;
    m_resp_o   = '0;
    m_rdata_bo = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_valid && gnt_idx == xarb_mid_t'(i)) begin
        s_we_o     = m_we_i[i];
        s_addr_bo  = m_addr_bi[i*32 +: 32];
        s_be_bo    = m_be_bi[i*4 +: 4];
        s_wdata_bo = m_wdata_bi[i*32 +: 32];
        m_ack_o[i] = hs;
      end
      if (resp_fire && fifo_head == xarb_mid_t'(i)) begin
        m_resp_o[i]             = 1'b1;
        m_rdata_bo[i*32 +: 32]  = resp_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (hs)    rr_ptr_q <= rr_ptr_d;
      if (stray) err_q    <= 1'b1;
    end
  end

  // Sticky debug flag and configuration kept visible without driving a port.
  logic unused_dbg;
  assign unused_dbg = ^{err_q, RESP_TIMEOUT};

  sigrun_xarb_fifo #(
    .DEPTH (RESP_FIFO_DEPTH),
    .WIDTH (XARB_MID_W)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (resp_fire),
    .data_i  (gnt_idx),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_sigrun_xbus_arbiter.sv
// Directed self-checking bench for sigrun_xbus_arbiter (2 masters, depth 4, timeout 16).
module tb_sigrun_xbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req, m_we, m_ack, m_resp;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_be;
  logic        s_req, s_we, s_ack, s_resp, busy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sigrun_xbus_arbiter #(
    .NUM_MASTERS     (2),
    .RESP_FIFO_DEPTH (4),
    .RESP_TIMEOUT    (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m_req_i    (m_req),
    .m_we_i     (m_we),
    .m_addr_bi  (m_addr),
    .m_be_bi    (m_be),
    .m_wdata_bi (m_wdata),
    .m_ack_o    (m_ack),
    .m_resp_o   (m_resp),
    .m_rdata_bo (m_rdata),
    .s_req_o    (s_req),
    .s_we_o     (s_we),
    .s_addr_bo  (s_addr),
    .s_be_bo    (s_be),
    .s_wdata_bo (s_wdata),
    .s_ack_i    (s_ack),
    .s_resp_i   (s_resp),
    .s_rdata_bi (s_rdata),
    .busy_o     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; inputs are driven there and outputs checked 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_be = 8'hFF; m_wdata = '0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    next_cycle(); next_cycle();
    rst = 1'b0; #1;
    chk("reset_busy",  64'(busy),    64'h0);
    chk("reset_sreq",  64'(s_req),   64'h0);
    chk("reset_ack",   64'(m_ack),   64'h0);
    chk("reset_resp",  64'(m_resp),  64'h0);
    chk("reset_rdata", m_rdata,      64'h0);

    // Lone write from M1
    next_cycle();
    m_req = 2'b10; m_we = 2'b10; m_addr = {32'h8000_0000, 32'h0}; m_wdata = {32'h5, 32'h0};
    s_ack = 1'b1; #1;
    chk("wr_sreq",  64'(s_req),   64'h1);
    chk("wr_swe",   64'(s_we),    64'h1);
    chk("wr_addr",  64'(s_addr),  64'h8000_0000);
    chk("wr_wdata", 64'(s_wdata), 64'h5);
    chk("wr_ack",   64'(m_ack),   64'h2);
    chk("wr_resp",  64'(m_resp),  64'h0);
    next_cycle();
    m_req = '0; m_we = '0; s_ack = 1'b0; #1;
    chk("wr_busy_after", 64'(busy),   64'h0);
    chk("wr_resp_after", 64'(m_resp), 64'h0);

    // Both masters read back-to-back; grants alternate and responses follow issue order
    m_addr = {32'h200, 32'h100};
    next_cycle();
    m_req = 2'b11; s_ack = 1'b1; #1;
    chk("rr_a_ack",  64'(m_ack),  64'h1);
    chk("rr_a_addr", 64'(s_addr), 64'h100);
    next_cycle();
    s_resp = 1'b1; s_rdata = 32'hA0; #1;
    chk("rr_b_ack",   64'(m_ack),  64'h2);
    chk("rr_b_addr",  64'(s_addr), 64'h200);
    chk("rr_b_resp",  64'(m_resp), 64'h1);
    chk("rr_b_rdata", m_rdata,     {32'h0, 32'hA0});
    next_cycle();
    s_rdata = 32'hA1; #1;
    chk("rr_c_ack",   64'(m_ack),  64'h1);
    chk("rr_c_resp",  64'(m_resp), 64'h2);
    chk("rr_c_rdata", m_rdata,     {32'hA1, 32'h0});
    next_cycle();
    s_rdata = 32'hA2; #1;
    chk("rr_d_ack",   64'(m_ack),  64'h2);
    chk("rr_d_rdata", m_rdata,     {32'h0, 32'hA2});
    next_cycle();
    m_req = '0; s_ack = 1'b0; s_rdata = 32'hA3; #1;
    chk("rr_e_resp",  64'(m_resp), 64'h2);
    chk("rr_e_rdata", m_rdata,     {32'hA3, 32'h0});
    next_cycle();
    s_resp = 1'b0; #1;
    chk("rr_drained", 64'(busy), 64'h0);

    // M0 fills the FIFO; fifth read stalls until a response frees a slot
    m_addr = {32'h200, 32'h300};
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      m_req = 2'b01; s_ack = 1'b1; #1;
      chk($sformatf("fill_ack%0d", k), 64'(m_ack), 64'h1);
    end
    next_cycle(); #1;
    chk("full_sreq", 64'(s_req), 64'h0);
    chk("full_ack",  64'(m_ack), 64'h0);
    chk("full_busy", 64'(busy),  64'h1);
    next_cycle();
    s_resp = 1'b1; s_rdata = 32'hB0; #1;
    chk("full_pop_resp",  64'(m_resp), 64'h1);
    chk("full_pop_rdata", m_rdata,     {32'h0, 32'hB0});
    chk("full_pop_noack", 64'(m_ack),  64'h0);
    next_cycle();
    s_resp = 1'b0; #1;
    chk("released_ack", 64'(m_ack), 64'h1);
    next_cycle();
    m_req = '0; s_ack = 1'b0; s_resp = 1'b1; s_rdata = 32'hB1; #1;
    chk("pop_to3_resp", 64'(m_resp), 64'h1);

    // FIFO at 3: same-cycle pop and push keep the count at 3
    next_cycle();
    m_req = 2'b01; s_ack = 1'b1; s_rdata = 32'hB2; #1;
    chk("pp_ack",   64'(m_ack),  64'h1);
    chk("pp_resp",  64'(m_resp), 64'h1);
    chk("pp_rdata", m_rdata,     {32'h0, 32'hB2});
    next_cycle();
    m_req = '0; s_ack = 1'b0;
    next_cycle();
    next_cycle(); #1;
    chk("pp_last_busy", 64'(busy), 64'h1);
    next_cycle();
    s_resp = 1'b0; #1;
    chk("pp_empty", 64'(busy), 64'h0);

    // Reset with three reads outstanding
    m_addr = {32'h200, 32'h100};
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      m_req = 2'b01; s_ack = 1'b1;
    end
    next_cycle();
    m_req = '0; s_ack = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0; s_resp = 1'b1; s_rdata = 32'hC0; #1;
    chk("mrst_busy",  64'(busy),   64'h0);
    chk("mrst_resp",  64'(m_resp), 64'h0);
    chk("mrst_rdata", m_rdata,     64'h0);
    chk("mrst_sreq",  64'(s_req),  64'h0);
    next_cycle();
    s_resp = 1'b0; m_req = 2'b11; #1;
    chk("mrst_ptr0", 64'(s_addr), 64'h100);
    chk("mrst_busy2", 64'(busy),  64'h0);
    next_cycle();
    m_req = '0;

`ifdef SIGRUN_XARB_TIMEOUT_EN
    // Silent slave: timeout answers with the poison word, late response is swallowed
    next_cycle();
    m_req = 2'b01; s_ack = 1'b1; #1;
    chk("to_ack", 64'(m_ack), 64'h1);
    for (int k = 1; k < 16; k++) begin
      next_cycle();
      m_req = '0; s_ack = 1'b0; #1;
      chk($sformatf("to_wait%0d", k), 64'(m_resp), 64'h0);
    end
    next_cycle(); #1;
    chk("to_resp",  64'(m_resp), 64'h1);
    chk("to_rdata", m_rdata,     {32'h0, 32'hDEAD_BEEF});
    next_cycle(); #1;
    chk("to_idle", 64'(busy), 64'h0);
    next_cycle();
    s_resp = 1'b1; s_rdata = 32'h77; #1;
    chk("to_swallow", 64'(m_resp), 64'h0);
    next_cycle();
    s_resp = 1'b0; m_req = 2'b01; s_ack = 1'b1;
    next_cycle();
    m_req = '0; s_ack = 1'b0; s_resp = 1'b1; s_rdata = 32'h88; #1;
    chk("to_after_resp",  64'(m_resp), 64'h1);
    chk("to_after_rdata", m_rdata,     {32'h0, 32'h88});
    next_cycle();
    s_resp = 1'b0;
`endif

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
